// File: rtl/gaussian_array.sv
// Multi-lane CLT Gaussian generator: per-lane Fibonacci LFSRs are summed over 2^LOG2_NSUM
// steps, averaged, scaled and offset, then presented together behind one valid/ready register.
module gaussian_array #(
    parameter int unsigned NCH             = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FRACTIONAL_BITS = 24,
    parameter int unsigned LOG2_NSUM       = 2,
    parameter int unsigned SHIFTAMT        = 7,
    parameter logic [DATA_WIDTH-1:0]    OFFSET      = 32'hFFFD_F3B7,
    parameter logic [FRACTIONAL_BITS:0] SEED_STRIDE = 25'h13_579B
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      load_seed,
    input  logic [FRACTIONAL_BITS:0]  seed,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [NCH*DATA_WIDTH-1:0] randnum,
    output logic [15:0]               sample_count
);

    localparam int unsigned W    = FRACTIONAL_BITS + 1;
    localparam int unsigned AW   = W + LOG2_NSUM;
    localparam int unsigned NSUM = 1 << LOG2_NSUM;
    localparam int unsigned CW   = (LOG2_NSUM > 0) ? LOG2_NSUM : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSUM - 1);

    logic [W-1:0]              lfsr_q [NCH];
    logic [W-1:0]              lfsr_d [NCH];
    logic [AW-1:0]             acc_q  [NCH];
    logic [AW-1:0]             acc_d  [NCH];
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [NCH*DATA_WIDTH-1:0] randnum_q, randnum_d;
    logic [15:0]               count_q, count_d;

    logic [W-1:0]              lane_seed_c [NCH];
    logic [W-1:0]              step_c      [NCH];
    logic [AW-1:0]             sum_c       [NCH];
    logic [DATA_WIDTH-1:0]     result_c    [NCH];
    logic                      last_c, stall_c, advance_c, xfer_c;

    // Per-lane seed, LFSR successor and the result a batch would produce if it closed now.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            lane_seed_c[c] = seed + W'(c) * SEED_STRIDE;
            if (lane_seed_c[c] == '0) begin
                lane_seed_c[c] = W'(1);
            end
            step_c[c]   = {lfsr_q[c][W-2:0], lfsr_q[c][W-1] ^ lfsr_q[c][W-4]};
            sum_c[c]    = acc_q[c] + AW'(lfsr_q[c]);
            result_c[c] = DATA_WIDTH'((sum_c[c] >> LOG2_NSUM) >> SHIFTAMT) + OFFSET;
        end
    end

    // Generation stalls only when a batch is ready to close but the output slot is still occupied.
    assign last_c    = (cnt_q == CNT_LAST);
    assign stall_c   = last_c && Enable && out_valid_q && !out_ready;
    assign advance_c = Enable && !stall_c;
    assign xfer_c    = out_valid_q && out_ready;

    always_comb begin
        lfsr_d      = lfsr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        randnum_d   = randnum_q;
        count_d     = count_q;
        if (load_seed) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                lfsr_d[c] = lane_seed_c[c];
                acc_d[c]  = '0;
            end
            cnt_d = '0;
        end else begin
            if (xfer_c) begin
                count_d     = count_q + 16'd1;
                out_valid_d = 1'b0;
            end
            if (advance_c) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    lfsr_d[c] = step_c[c];
                    acc_d[c]  = last_c ? '0 : sum_c[c];
                    if (last_c) begin
                        randnum_d[c*DATA_WIDTH +: DATA_WIDTH] = result_c[c];
                    end
                end
                cnt_d = last_c ? '0 : cnt_q + CW'(1);
                if (last_c) begin
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                lfsr_q[c] <= lane_seed_c[c];
                acc_q[c]  <= '0;
            end
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            randnum_q   <= '0;
            count_q     <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                lfsr_q[c] <= lfsr_d[c];
                acc_q[c]  <= acc_d[c];
            end
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            randnum_q   <= randnum_d;
            count_q     <= count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign randnum      = randnum_q;
    assign sample_count = count_q;

endmodule

// File: doc/gaussian_array.md
Name: gaussian_array

Overview:
- Multi-channel, pipelined successor to the single-channel fixed-point Gaussian generator used by the LBM velocity initialisation.
- Each of NCH lanes runs its own Fibonacci LFSR and approximates a normal deviate by the central limit theorem: it sums 2^LOG2_NSUM consecutive LFSR states, averages, scales and offsets the result.
- All lanes deliver results together through a valid/ready output register with backpressure, so consumers (e.g. UX/UY field initialisers) can stall generation.

Parameters:
- NCH, 2, number of independent lanes.
- DATA_WIDTH, 32, output word width per lane.
- FRACTIONAL_BITS, 24, LFSR width is W = FRACTIONAL_BITS+1.
- LOG2_NSUM, 2, log2 of samples summed per result; 0 allowed (no summing).
- SHIFTAMT, 7, right shift applied after averaging.
- OFFSET, 32'hFF_FDF3B7, added to the scaled value, mod 2^DATA_WIDTH.
- SEED_STRIDE, 25'h13_579B, per-lane seed increment.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  advance generation when high.
- load_seed  in  1  synchronous reseed strobe.
- seed  in  W  base seed.
- out_ready  in  1  consumer accepts the output.
- out_valid  out  1  randnum holds an unconsumed result.
- randnum  out  NCH*DATA_WIDTH  lane c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- sample_count  out  16  handshakes completed, wraps at 2^16.

Behaviour:
- Lane seed: s_c = (seed + c*SEED_STRIDE) mod 2^W. If s_c == 0, use 1 instead.
- LFSR step: next = {state[W-2:0], state[W-1]^state[W-4]} (x^25+x^22+1 at default width).
- Reset:
  - LFSRs loaded with s_c.
  - acc = 0, cnt = 0.
  - out_valid = 0, randnum = 0, sample_count = 0.
  - Reset overrides all other inputs.
- load_seed (Reset low):
  - LFSRs reload s_c; acc and cnt clear.
  - Output register, out_valid and sample_count are unchanged.
  - Takes priority over Enable in the same cycle.
- States: ACCUM (cnt < NSUM-1), LAST (cnt == NSUM-1), STALL (LAST, Enable=1, output occupied and out_ready=0).
- Output free this cycle = !out_valid || out_ready.
- Enable=1 and not STALL:
  - Every lane adds its current state (zero-extended, unsigned) into acc (width W+LOG2_NSUM).
  - LFSR steps; cnt increments.
- In LAST and output free:
  - total = acc + state.
  - randnum_c = zero-extend((total >> LOG2_NSUM) >> SHIFTAMT) + OFFSET, truncated to DATA_WIDTH.
  - out_valid <= 1; acc <= 0; cnt <= 0.
- STALL: LFSR, acc and cnt all hold.
- Enable=0: LFSR, acc and cnt hold; the handshake still operates.
- Handshake:
  - Transfer occurs when out_valid && out_ready; sample_count increments.
  - out_valid clears unless a new result loads in the same cycle (then it stays 1 with the new data).
  - randnum and out_valid are stable while out_valid && !out_ready.
- Latency: first out_valid rises on the NSUM-th Enable edge after Reset/load_seed. Throughput is one result per NSUM cycles. Next-batch accumulation overlaps a held output.
- All lanes operate in lockstep: one out_valid covers every lane.

Test Plan:
- NCH=1, LOG2_NSUM=0, SHIFTAMT=0, OFFSET=0, seed=1, Enable=1, out_ready=1 -> randnum 1,2,4,8,... on consecutive cycles; out_valid stays 1; sample_count increments each cycle.
- Defaults, seed=1, lane 0:
  - Samples 1,2,4,8 -> total 15; 15>>2 = 3; 3>>7 = 0.
  - randnum lane 0 = 32'hFFFD_F3B7 after 4 Enable cycles.
  - Same settings with SHIFTAMT=0, OFFSET=0 -> 3.
- seed=0, NCH=2, SEED_STRIDE=1, LOG2_NSUM=0, SHIFTAMT=0, OFFSET=0 -> lane0 starts 1 (zero substituted), lane1 starts 1 -> both lanes show 1,2,4,...
- Backpressure, defaults, out_ready=0:
  - out_valid rises at cycle 4; second batch accumulates through cycle 7, then stalls.
  - randnum stays constant for 20 cycles.
  - Raise out_ready -> handshake that cycle; second result valid on the same edge; sample_count = 1.
- Reset asserted mid-batch (cnt=2) with out_valid=1 -> next cycle out_valid=0, randnum=0, and the restart reproduces the first-batch values exactly.
- load_seed pulsed with out_valid=1, out_ready=0 -> held output unchanged; the next result equals the fresh-seed first-batch value.
